// File: rtl/trace_capture_buf.sv
// Circular trace capture buffer with pre-trigger window and post-trigger freeze.
// Frozen contents are drained oldest-first through a request/valid read port.
module trace_capture_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int POST  = 8
) (
    input  logic          clk,
    input  logic          MRST,
    input  logic          arm,
    input  logic [9:0]    EV,
    input  logic [31:0]   TP,
    input  logic          TPE,
    input  logic          rd_req,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    output logic          rd_last,
    output logic [1:0]    state,
    output logic [AW:0]   count,
    output logic [15:0]   drop_cnt,
    output logic [1:0]    trig_src,
    output logic [7:0]    trig_code
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   POST_C  = (AW+1)'(POST);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   post_cnt_q, post_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [1:0]    trig_src_q, trig_src_d;
    logic [7:0]    trig_code_q, trig_code_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;

    logic [31:0]   mem [DEPTH];

    logic          trig_hit;
    logic          restart;
    logic          wr_en;
    logic          rd_fire;

    assign trig_hit = |EV[7:0];

    always_comb begin
        state_d     = state_q;
        post_cnt_d  = post_cnt_q;
        trig_src_d  = trig_src_q;
        trig_code_d = trig_code_q;
        restart     = 1'b0;
        wr_en       = 1'b0;
        rd_fire     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                restart = arm;
            end
            S_ARMED: begin
                if (arm) begin
                    restart = 1'b1;
                end else begin
                    wr_en = TPE;
                    if (trig_hit) begin
                        state_d     = S_CAPTURE;
                        trig_src_d  = EV[9:8];
                        trig_code_d = EV[7:0];
                        // A word written in the trigger cycle is post word 1
                        post_cnt_d  = TPE ? ONE_C : '0;
                        if (TPE && (POST_C == ONE_C)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_CAPTURE: begin
                if (TPE) begin
                    wr_en      = 1'b1;
                    post_cnt_d = post_cnt_q + ONE_C;
                    if (post_cnt_d == POST_C) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (arm) begin
                    restart = 1'b1;
                end else if (rd_last_q) begin
                    state_d = S_IDLE;
                end else if (rd_req && (count_q != '0)) begin
                    rd_fire = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (restart) begin
            state_d    = S_ARMED;
            post_cnt_d = '0;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        rd_data_d  = '0;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        if (restart) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = '0;
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (count_q == DEPTH_C) begin
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end else begin
                count_d = count_q + ONE_C;
            end
        end
        // In DONE the count register doubles as the remaining-word counter
        if (rd_fire) begin
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_last_d  = (count_q == ONE_C);
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            count_d    = count_q - ONE_C;
        end
        if ((state_q != S_DONE) && (state_d == S_DONE)) begin
            rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !MRST) begin
            mem[wr_ptr_q] <= TP;
        end
    end

    always_ff @(posedge clk) begin
        if (MRST) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            trig_src_q  <= '0;
            trig_code_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_cnt_q  <= post_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            trig_src_q  <= trig_src_d;
            trig_code_q <= trig_code_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    assign state     = state_q;
    assign count     = count_q;
    assign drop_cnt  = drop_cnt_q;
    assign trig_src  = trig_src_q;
    assign trig_code = trig_code_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;

    a_count_bound: assert property (
        @(posedge clk) disable iff (MRST) count_q <= DEPTH_C
    );
    a_last_valid: assert property (
        @(posedge clk) disable iff (MRST) rd_last_q |-> rd_valid_q
    );
    a_data_idle: assert property (
        @(posedge clk) disable iff (MRST) !rd_valid_q |-> (rd_data_q == '0)
    );

endmodule

// File: tb/tb_trace_capture_buf.sv
// Bench for trace_capture_buf: vector table, directed sequences and a
// randomized run checked against a queue-based model of the capture buffer.
module tb_trace_capture_buf;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int POST  = 8;

    logic        clk = 1'b0;
    logic        MRST = 1'b1;
    logic        arm = 1'b0;
    logic [9:0]  EV = '0;
    logic [31:0] TP = '0;
    logic        TPE = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic [1:0]  state;
    logic [AW:0] count;
    logic [15:0] drop_cnt;
    logic [1:0]  trig_src;
    logic [7:0]  trig_code;

    int total = 0;
    int bad = 0;

    trace_capture_buf #(.DEPTH(DEPTH), .AW(AW), .POST(POST)) dut (
        .clk(clk), .MRST(MRST), .arm(arm), .EV(EV), .TP(TP), .TPE(TPE),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_last(rd_last), .state(state), .count(count),
        .drop_cnt(drop_cnt), .trig_src(trig_src), .trig_code(trig_code)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: the buffer is simply a queue of held words
    int          m_state = 0;
    logic [31:0] m_buf[$];
    int          m_drop = 0;
    int          m_post = 0;
    logic [1:0]  m_src = 0;
    logic [7:0]  m_code = 0;
    logic        m_rdv = 0;
    logic [31:0] m_rdd = 0;
    logic        m_rdl = 0;

    function automatic void m_restart();
        m_state = 1;
        m_buf.delete();
        m_drop = 0;
        m_post = 0;
    endfunction

    function automatic void m_push(input logic [31:0] w);
        if (m_buf.size() == DEPTH) begin
            void'(m_buf.pop_front());
            if (m_drop < 16'hFFFF) m_drop++;
        end
        m_buf.push_back(w);
    endfunction

    function automatic void model_step(input logic a, input logic [9:0] e,
                                       input logic [31:0] t, input logic v,
                                       input logic r, input logic rs);
        logic        nv = 1'b0;
        logic [31:0] nd = '0;
        logic        nl = 1'b0;
        if (rs) begin
            m_state = 0; m_buf.delete(); m_drop = 0; m_post = 0;
            m_src = 0; m_code = 0; m_rdv = 0; m_rdd = 0; m_rdl = 0;
            return;
        end
        case (m_state)
            0: if (a) m_restart();
            1: begin
                if (a) m_restart();
                else begin
                    if (v) m_push(t);
                    if (e[7:0] != 0) begin
                        m_src = e[9:8];
                        m_code = e[7:0];
                        m_post = v ? 1 : 0;
                        m_state = (v && POST == 1) ? 3 : 2;
                    end
                end
            end
            2: if (v) begin
                m_push(t);
                m_post++;
                if (m_post == POST) m_state = 3;
            end
            default: begin
                if (a) m_restart();
                else if (m_rdl) m_state = 0;
                else if (r && m_buf.size() > 0) begin
                    nd = m_buf.pop_front();
                    nv = 1'b1;
                    nl = (m_buf.size() == 0);
                end
            end
        endcase
        m_rdv = nv;
        m_rdd = nd;
        m_rdl = nl;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic a, input logic [9:0] e,
                       input logic [31:0] t, input logic v,
                       input logic r, input logic rs);
        arm = a; EV = e; TP = t; TPE = v; rd_req = r; MRST = rs;
        @(posedge clk);
        #1;
        model_step(a, e, t, v, r, rs);
        chk("m_state", 32'(state), 32'(m_state));
        chk("m_count", 32'(count), 32'(m_buf.size()));
        chk("m_drop", 32'(drop_cnt), 32'(m_drop));
        chk("m_src", 32'(trig_src), 32'(m_src));
        chk("m_code", 32'(trig_code), 32'(m_code));
        chk("m_rdv", 32'(rd_valid), 32'(m_rdv));
        chk("m_rdd", rd_data, m_rdd);
        chk("m_rdl", 32'(rd_last), 32'(m_rdl));
    endtask

    logic [31:0] expq[$];

    task automatic drain(input string nm);
        int n = 0;
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc(0, 0, 0, 0, 1, 0);
            if (rd_valid) begin
                if (n < expq.size()) chk({nm, "_data"}, rd_data, expq[n]);
                n++;
                chk({nm, "_last"}, 32'(rd_last), 32'(n == expq.size()));
                if (rd_last) seen = 1;
            end
        end
        chk({nm, "_nwords"}, 32'(n), 32'(expq.size()));
        cyc(0, 0, 0, 0, 0, 0);
        chk({nm, "_idle"}, 32'(state), 32'd0);
    endtask

    typedef struct {
        logic        a;
        logic [9:0]  e;
        logic [31:0] t;
        logic        v;
        logic        r;
        logic        rs;
        logic [1:0]  st;
        logic [4:0]  cnt;
        logic        rdv;
        logic [31:0] rdd;
    } vec_t;

    vec_t tbl[18];

    task automatic setv(input int i, input logic a, input logic [9:0] e,
                        input logic [31:0] t, input logic v, input logic r,
                        input logic rs, input logic [1:0] st,
                        input logic [4:0] c, input logic rv,
                        input logic [31:0] rd);
        tbl[i].a = a; tbl[i].e = e; tbl[i].t = t; tbl[i].v = v;
        tbl[i].r = r; tbl[i].rs = rs; tbl[i].st = st; tbl[i].cnt = c;
        tbl[i].rdv = rv; tbl[i].rdd = rd;
    endtask

    initial begin
        int pat[6];
        int pulses;
        logic        ra, rv, rr, rrs;
        logic [9:0]  re;

        // arm with EV in IDLE, src-only EV, arm ignored in CAPTURE,
        // arm discarding unread data in DONE
        setv(0, 0, 10'h000, 32'h00, 0, 0, 1, 0, 0, 0, 0);
        setv(1, 0, 10'h004, 32'hAA, 1, 0, 0, 0, 0, 0, 0);
        setv(2, 1, 10'h002, 32'h00, 0, 0, 0, 1, 0, 0, 0);
        setv(3, 0, 10'h000, 32'h21, 1, 0, 0, 1, 1, 0, 0);
        setv(4, 0, 10'h300, 32'h22, 1, 0, 0, 1, 2, 0, 0);
        setv(5, 0, 10'h080, 32'h00, 0, 0, 0, 2, 2, 0, 0);
        setv(6, 0, 10'h000, 32'h23, 1, 0, 0, 2, 3, 0, 0);
        setv(7, 1, 10'h000, 32'h24, 1, 0, 0, 2, 4, 0, 0);
        for (int i = 0; i < 6; i++)
            setv(8 + i, 0, 10'h000, 32'h25 + i, 1, 0, 0,
                 (i == 5) ? 2'd3 : 2'd2, 5'(5 + i), 0, 0);
        setv(14, 0, 10'h000, 32'h00, 0, 1, 0, 3, 9, 1, 32'h21);
        setv(15, 0, 10'h000, 32'h00, 0, 0, 0, 3, 9, 0, 0);
        setv(16, 1, 10'h000, 32'h00, 0, 1, 0, 1, 0, 0, 0);
        setv(17, 0, 10'h000, 32'h00, 0, 0, 1, 0, 0, 0, 0);

        // Basic session
        cyc(0, 0, 0, 0, 0, 1);
        chk("t1_rst_state", 32'(state), 0);
        chk("t1_rst_count", 32'(count), 0);
        chk("t1_rst_rdv", 32'(rd_valid), 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t1_armed", 32'(state), 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 32'h11 + i, 1, 0, 0);
        cyc(0, 10'h001, 32'h16, 1, 0, 0);
        chk("t1_capture", 32'(state), 2);
        for (int i = 0; i < 7; i++) cyc(0, 0, 32'h17 + i, 1, 0, 0);
        chk("t1_done", 32'(state), 3);
        chk("t1_count", 32'(count), 13);
        chk("t1_drop", 32'(drop_cnt), 0);
        chk("t1_code", 32'(trig_code), 32'h01);
        expq.delete();
        for (int i = 0; i < 13; i++) expq.push_back(32'h11 + i);
        drain("t1");

        // Wrap and overflow
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, i, 1, 0, 0);
        chk("t2_pre_count", 32'(count), 16);
        cyc(0, 10'h001, 32'hDEAD, 0, 0, 0);
        chk("t2_capture", 32'(state), 2);
        for (int i = 0; i < 8; i++) cyc(0, 0, 100 + i, 1, 0, 0);
        chk("t2_done", 32'(state), 3);
        chk("t2_count", 32'(count), 16);
        chk("t2_drop", 32'(drop_cnt), 12);
        expq.delete();
        for (int i = 12; i < 20; i++) expq.push_back(i);
        for (int i = 0; i < 8; i++) expq.push_back(100 + i);
        drain("t2");

        // Trigger without TPE needs exactly POST further words
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 10'h305, 32'hBEEF, 0, 0, 0);
        chk("t3_state", 32'(state), 2);
        chk("t3_src", 32'(trig_src), 3);
        chk("t3_code", 32'(trig_code), 32'h05);
        for (int i = 0; i < 7; i++) cyc(0, 10'h0FF, 32'h300 + i, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t3_still_cap", 32'(state), 2);
        chk("t3_src_kept", 32'(trig_src), 3);
        chk("t3_code_kept", 32'(trig_code), 32'h05);
        cyc(0, 0, 32'h307, 1, 0, 0);
        chk("t3_done", 32'(state), 3);
        chk("t3_count", 32'(count), 8);

        // Paused readout of the last three words
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            chk("t4_pre", rd_data, 32'h300 + i);
        end
        chk("t4_remain", 32'(count), 3);
        pat = '{1, 0, 1, 1, 0, 1};
        pulses = 0;
        for (int j = 0; j < 6; j++) begin
            cyc(0, 0, 0, 0, 1'(pat[j]), 0);
            if (rd_valid) begin
                chk("t4_data", rd_data, 32'h305 + pulses);
                chk("t4_last", 32'(rd_last), 32'(pulses == 2));
                pulses++;
            end
        end
        chk("t4_pulses", 32'(pulses), 3);
        chk("t4_idle", 32'(state), 0);

        // Reset during CAPTURE
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 10'h001, 32'hA0, 1, 0, 0);
        cyc(0, 0, 32'hA1, 1, 0, 0);
        cyc(0, 0, 32'hA2, 1, 0, 0);
        chk("t5_cap", 32'(state), 2);
        chk("t5_cap_count", 32'(count), 3);
        cyc(0, 0, 32'hA3, 1, 1, 1);
        chk("t5_state", 32'(state), 0);
        chk("t5_count", 32'(count), 0);
        chk("t5_rdv", 32'(rd_valid), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 10'h001, $urandom, 1, 1, 0);
            chk("t5_nowrite", 32'(count), 0);
        end
        cyc(1, 0, 0, 0, 0, 0);
        chk("t5_rearm_count", 32'(count), 0);

        // Vector table
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].a, tbl[i].e, tbl[i].t, tbl[i].v, tbl[i].r, tbl[i].rs);
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_rdv", i), 32'(rd_valid), 32'(tbl[i].rdv));
            chk($sformatf("vec%0d_rdd", i), rd_data, tbl[i].rdd);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rrs = ($urandom_range(0, 299) == 0);
            ra  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) re = 10'($urandom);
            else re = {2'($urandom), 8'h00};
            rv  = 1'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 3) != 0);
            cyc(ra, re, $urandom, rv, rr, rrs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_capture_buf.md
Name: trace_capture_buf

Overview:
Receive-side sink for the debug block's trace port. Captures TP words qualified by TPE into a circular on-chip buffer with a pre-trigger window. The event code on EV[7:0] acts as the trigger; capture freezes after a programmable number of post-trigger words. A host/debugger drains the frozen buffer oldest-first over a simple request/valid read port. Sits between the debug logic and the external debugger / security wrapper.

Parameters:
DEPTH, 16, buffer entries; power of two, minimum 4.
AW, 4, log2(DEPTH).
POST, 8, post-trigger words to capture; 1 <= POST <= DEPTH.

Ports:
clk  in  1  system clock; all logic on the rising edge.
MRST  in  1  synchronous reset, active-high.
arm  in  1  single-cycle pulse; (re)starts a capture session.
EV  in  10  event bus from debug logic; trigger when EV[7:0] != 0. EV[9:8] is the source tag, latched at trigger.
TP  in  32  trace word.
TPE  in  1  trace word valid.
rd_req  in  1  host read request, level.
rd_data  out  32  read word.
rd_valid  out  1  rd_data is valid this cycle.
rd_last  out  1  marks the final word of the session; asserted with rd_valid.
state  out  2  0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE.
count  out  AW+1  number of valid words in the buffer, 0..DEPTH.
drop_cnt  out  16  number of overwritten oldest words, saturating at 16'hFFFF.
trig_src  out  2  EV[9:8] latched at trigger.
trig_code  out  8  EV[7:0] latched at trigger.

Behaviour:
- Reset (MRST=1 at clk edge):
  - state=IDLE.
  - wr_ptr, rd_ptr, count, post_cnt, drop_cnt, trig_src, trig_code, rd_data, rd_valid, rd_last all 0.
  - Buffer memory is not cleared.
  - Reset mid-session aborts the session immediately. No partial readout.
- IDLE:
  - TPE, EV and rd_req are ignored.
  - arm: next cycle ARMED with wr_ptr=0, count=0, post_cnt=0, drop_cnt=0.
- ARMED:
  - Each TPE=1 cycle writes TP to mem[wr_ptr]. wr_ptr increments modulo DEPTH.
  - count increments, saturating at DEPTH.
  - A write when count==DEPTH overwrites the oldest word and increments drop_cnt (saturating).
  - Trigger (EV[7:0]!=0):
    - next state CAPTURE; latch trig_src and trig_code.
    - If TPE is high in the trigger cycle, that word is written and counts as post word 1. Otherwise post_cnt stays 0.
    - If POST==1 and TPE is high in the trigger cycle, go directly to DONE.
- CAPTURE:
  - Writes continue exactly as in ARMED; each write increments post_cnt.
  - The write that makes post_cnt==POST is stored; the next state is DONE.
  - Further EV events are ignored; latched trigger info is kept.
- DONE:
  - No writes.
  - On entry, rd_ptr = (wr_ptr - count) mod DEPTH, i.e. the oldest word.
  - Internal remaining = count; the count output holds until readout starts, then tracks remaining.
- Readout (DONE only):
  - A cycle with rd_req=1 and remaining>0 issues a read of mem[rd_ptr]. rd_ptr increments modulo DEPTH and remaining decrements.
  - The registered result appears the next cycle with rd_valid=1; rd_last=1 when the issued read had remaining==1.
  - rd_valid is otherwise 0, with rd_data=0 and rd_last=0.
  - rd_req may drop at any time; readout pauses and resumes without loss.
  - The cycle after rd_last is output, state returns to IDLE.
- arm handling:
  - arm in ARMED restarts the session (pointers and counts cleared).
  - arm in CAPTURE is ignored.
  - arm in DONE discards unread data and goes to ARMED.
  - arm has priority over a trigger or read request in the same cycle.
- Widths: post_cnt and pointers wrap only as specified; count never exceeds DEPTH.

Test Plan:
1. Reset, then arm; 5 TPE words 0x11..0x15; EV=0x001 with TPE and TP=0x16; 7 more words 0x17..0x1D → DONE, count=13, drop_cnt=0, trig_code=0x01; readout yields 0x11..0x1D, rd_last on 0x1D, then IDLE.
2. Wrap/overflow: arm; 20 words 0..19 pre-trigger; trigger without TPE; 8 words 100..107 → count=16, drop_cnt=12; readout starts at word 12 (value 12) and ends at 107.
3. EV=0x305 with TPE low in the trigger cycle → trig_src=3, trig_code=0x05, post_cnt=0; exactly 8 subsequent TPE words are needed to reach DONE.
4. Readout with rd_req toggling 1,0,1,1,0,1 on a 3-word buffer → exactly 3 rd_valid pulses, in order, rd_last on the third.
5. MRST asserted in CAPTURE after 3 post words → next cycle state=IDLE, count=0, rd_valid=0; TPE activity afterwards causes no writes.
6. arm together with EV=0x002 in IDLE → ARMED with no trigger; arm pulse in CAPTURE → no effect, DONE is still reached after POST words.
